// File: rtl/naive_bus_pkg.sv
// Shared definitions for the naive bus RAM slave.
// Holds lane geometry and the grant FSM state encoding.
package naive_bus_pkg;

    localparam int unsigned LANES    = 4;
    localparam int unsigned OFFSET_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_GRANT
    } state_t;

endpackage

// File: rtl/naive_bus_if.sv
// Naive request/grant bus with separate read and write channels.
// The slave modport is consumed by naive_bus_ram_slave.
interface naive_bus
    import naive_bus_pkg::*;
();

    logic                 rd_req;
    logic                 rd_gnt;
    logic [31:0]          rd_addr;
    logic [31:0]          rd_data;
    logic                 wr_req;
    logic                 wr_gnt;
    logic [31:0]          wr_addr;
    logic [LANES-1:0]     wr_byte_enable;
    logic [31:0]          wr_data;

    modport slave (
        input  rd_req,
        input  rd_addr,
        output rd_gnt,
        output rd_data,
        input  wr_req,
        input  wr_addr,
        input  wr_byte_enable,
        input  wr_data,
        output wr_gnt
    );

    modport master (
        output rd_req,
        output rd_addr,
        input  rd_gnt,
        input  rd_data,
        output wr_req,
        output wr_addr,
        output wr_byte_enable,
        output wr_data,
        input  wr_gnt
    );

endinterface

// File: rtl/naive_bus_ram_array.sv
// Single-port synchronous RAM with byte-lane writes.
// Read data is registered and only changes on a read access.
module naive_bus_ram_array
    import naive_bus_pkg::*;
#(
    parameter int unsigned WORDS = 4096,
    parameter int unsigned AW    = 12
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [LANES-1:0] be,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [WORDS];

    // Port access: lane-masked write or registered read.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < LANES; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/naive_bus_ram_slave.sv
// RAM slave on the naive bus; write has priority over read.
// NAIVE_BUS_RAM_WAIT_EN adds a WAIT_CYCLES grant-delay FSM.
module naive_bus_ram_slave
    import naive_bus_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    naive_bus.slave   bus
);

    localparam int unsigned AW   = $clog2(MEM_WORDS);
    localparam logic [32:0] SPAN = 33'(MEM_WORDS) << OFFSET_W;

    if ((MEM_WORDS < 2) || ((MEM_WORDS & (MEM_WORDS - 1)) != 0)) begin : g_bad_words
        $error("MEM_WORDS must be a power of two >= 2");
    end
    if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 15)) begin : g_bad_wait
        $error("WAIT_CYCLES must be in 1..15");
    end

    logic        wr_gnt;
    logic        rd_gnt;
    logic [31:0] wr_off;
    logic [31:0] rd_off;
    logic        wr_hit;
    logic        rd_hit;
    logic        wr_fire;
    logic        rd_fire;
    logic        ram_en;
    logic [AW-1:0] ram_addr;
    logic [31:0] ram_q;
    logic        hit_q;

    assign wr_off = bus.wr_addr - BASE_ADDR;
    assign rd_off = bus.rd_addr - BASE_ADDR;
    assign wr_hit = {1'b0, wr_off} < SPAN;
    assign rd_hit = {1'b0, rd_off} < SPAN;

`ifdef NAIVE_BUS_RAM_WAIT_EN
    state_t     state;
    state_t     state_nx;
    logic [3:0] cnt;
    logic [3:0] cnt_nx;
    logic       sel_wr;
    logic       sel_wr_nx;
    logic       served;

    // Grant FSM state, countdown and selected channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= 4'd0;
            sel_wr <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            sel_wr <= sel_wr_nx;
        end
    end

    // Next state: wait out the delay, then one grant cycle.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        sel_wr_nx = sel_wr;
        wr_gnt    = 1'b0;
        rd_gnt    = 1'b0;
        served    = sel_wr ? bus.wr_req : bus.rd_req;
        unique case (state)
            ST_IDLE: begin
                if (bus.wr_req || bus.rd_req) begin
                    state_nx  = ST_WAIT;
                    cnt_nx    = 4'(WAIT_CYCLES - 1);
                    sel_wr_nx = bus.wr_req;
                end
            end
            ST_WAIT: begin
                if (!served) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = 4'd0;
                end else if (cnt <= 4'd1) begin
                    state_nx = ST_GRANT;
                    cnt_nx   = 4'd0;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            ST_GRANT: begin
                state_nx = ST_IDLE;
                wr_gnt   = sel_wr & bus.wr_req;
                rd_gnt   = ~sel_wr & bus.rd_req;
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = 4'd0;
            end
        endcase
    end
`else
    assign wr_gnt = rst_n & bus.wr_req;
    assign rd_gnt = rst_n & bus.rd_req & ~bus.wr_req;
`endif

    assign wr_fire  = wr_gnt;
    assign rd_fire  = rd_gnt;
    assign ram_en   = (wr_fire & wr_hit) | rd_fire;
    assign ram_addr = wr_fire ? wr_off[AW+1:2] : rd_off[AW+1:2];

    naive_bus_ram_array #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (wr_fire),
        .addr  (ram_addr),
        .be    (bus.wr_byte_enable),
        .wdata (bus.wr_data),
        .rdata (ram_q)
    );

    // Remember whether the last completed read hit the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q <= 1'b0;
        end else if (rd_fire) begin
            hit_q <= rd_hit;
        end
    end

    assign bus.wr_gnt  = wr_gnt;
    assign bus.rd_gnt  = rd_gnt;
    assign bus.rd_data = hit_q ? ram_q : 32'h0;

endmodule

// File: tb/tb_naive_bus_ram_slave.sv
// Testbench for naive_bus_ram_slave, default or wait-state build.
// Vector table for zero-wait mode, sequences for the FSM build.
module tb_naive_bus_ram_slave;
    import naive_bus_pkg::*;

    localparam int unsigned WORDS = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;
`ifdef NAIVE_BUS_RAM_WAIT_EN
    localparam int unsigned WC = 3;
`else
    localparam int unsigned WC = 2;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    naive_bus bus_if ();

    naive_bus_ram_slave #(
        .MEM_WORDS   (WORDS),
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [31:0] wa,
                         input logic [3:0] be, input logic [31:0] wd,
                         input logic rd, input logic [31:0] ra);
        bus_if.wr_req         = wr;
        bus_if.wr_addr        = wa;
        bus_if.wr_byte_enable = be;
        bus_if.wr_data        = wd;
        bus_if.rd_req         = rd;
        bus_if.rd_addr        = ra;
    endtask

`ifndef NAIVE_BUS_RAM_WAIT_EN
    typedef struct {
        logic        wr;
        logic [31:0] wa;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        rd;
        logic [31:0] ra;
        logic        ewg;
        logic        erg;
        logic        cd;
        logic [31:0] ed;
    } vec_t;

    vec_t v [20];

    function automatic vec_t mk(
        logic wr, logic [31:0] wa, logic [3:0] be, logic [31:0] wd,
        logic rd, logic [31:0] ra, logic ewg, logic erg,
        logic cd, logic [31:0] ed);
        vec_t r;
        r.wr = wr; r.wa = wa; r.be = be; r.wd = wd;
        r.rd = rd; r.ra = ra; r.ewg = ewg; r.erg = erg;
        r.cd = cd; r.ed = ed;
        return r;
    endfunction
`else
    task automatic wait_gnt(input bit is_wr, output int lat,
                            output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (is_wr ? bus_if.wr_gnt : bus_if.rd_gnt) begin
                ok  = 1'b1;
                lat = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_read(input string nm, input logic [31:0] a,
                           input logic [31:0] exp);
        int lat;
        bit ok;
        drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, a);
        wait_gnt(1'b0, lat, ok);
        chk({nm, " rd granted"}, 32'(ok), 32'd1);
        chk({nm, " rd latency"}, lat, WC);
        chk({nm, " no wr_gnt"}, 32'(bus_if.wr_gnt), 32'd0);
        @(negedge clk);
        bus_if.rd_req = 1'b0;
        chk({nm, " rd_data"}, bus_if.rd_data, exp);
    endtask

    task automatic do_write(input string nm, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] d);
        int lat;
        bit ok;
        drive(1'b1, a, be, d, 1'b0, 32'h0);
        wait_gnt(1'b1, lat, ok);
        chk({nm, " wr granted"}, 32'(ok), 32'd1);
        chk({nm, " wr latency"}, lat, WC);
        @(negedge clk);
        bus_if.wr_req = 1'b0;
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        drive(1'b1, BASE, 4'hF, 32'h1, 1'b1, BASE);
        repeat (3) @(negedge clk);
        #1;
        chk("reset wr_gnt", 32'(bus_if.wr_gnt), 32'd0);
        chk("reset rd_gnt", 32'(bus_if.rd_gnt), 32'd0);
        chk("reset rd_data", bus_if.rd_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef NAIVE_BUS_RAM_WAIT_EN
        v[0]  = mk(1, BASE+8,   4'hF, 32'hDEADBEEF, 0, 0,
                   1, 0, 0, 0);
        v[1]  = mk(0, 0, 4'h0, 0, 1, BASE+8,
                   0, 1, 0, 0);
        v[2]  = mk(0, 0, 4'h0, 0, 0, 0,
                   0, 0, 1, 32'hDEADBEEF);
        v[3]  = mk(1, BASE+4,   4'hF, 32'h11223344, 0, 0,
                   1, 0, 0, 0);
        v[4]  = mk(1, BASE+4,   4'h5, 32'hAABBCCDD, 0, 0,
                   1, 0, 0, 0);
        v[5]  = mk(0, 0, 4'h0, 0, 1, BASE+7,
                   0, 1, 0, 0);
        v[6]  = mk(0, 0, 4'h0, 0, 0, 0,
                   0, 0, 1, 32'h11BB33DD);
        v[7]  = mk(1, BASE+12,  4'hF, 32'h55667788, 1, BASE+12,
                   1, 0, 0, 0);
        v[8]  = mk(0, 0, 4'h0, 0, 1, BASE+12,
                   0, 1, 0, 0);
        v[9]  = mk(0, 0, 4'h0, 0, 0, 0,
                   0, 0, 1, 32'h55667788);
        v[10] = mk(1, BASE,     4'hF, 32'hCAFEF00D, 0, 0,
                   1, 0, 0, 0);
        v[11] = mk(0, 0, 4'h0, 0, 1, BASE+64,
                   0, 1, 1, 32'h55667788);
        v[12] = mk(1, BASE+64,  4'hF, 32'h12345678, 0, 0,
                   1, 0, 1, 32'h0);
        v[13] = mk(0, 0, 4'h0, 0, 1, BASE,
                   0, 1, 1, 32'h0);
        v[14] = mk(0, 0, 4'h0, 0, 0, 0,
                   0, 0, 1, 32'hCAFEF00D);
        v[15] = mk(1, BASE,     4'h0, 32'hFFFFFFFF, 0, 0,
                   1, 0, 0, 0);
        v[16] = mk(0, 0, 4'h0, 0, 1, BASE,
                   0, 1, 0, 0);
        v[17] = mk(0, 0, 4'h0, 0, 0, 0,
                   0, 0, 1, 32'hCAFEF00D);
        v[18] = mk(0, 0, 4'h0, 0, 1, BASE-4,
                   0, 1, 0, 0);
        v[19] = mk(0, 0, 4'h0, 0, 0, 0,
                   0, 0, 1, 32'h0);

        for (int i = 0; i < 20; i++) begin
            if (v[i].cd) begin
                chk($sformatf("v%0d rd_data", i), bus_if.rd_data, v[i].ed);
            end
            drive(v[i].wr, v[i].wa, v[i].be, v[i].wd, v[i].rd, v[i].ra);
            #1;
            chk($sformatf("v%0d wr_gnt", i), 32'(bus_if.wr_gnt),
                32'(v[i].ewg));
            chk($sformatf("v%0d rd_gnt", i), 32'(bus_if.rd_gnt),
                32'(v[i].erg));
            @(negedge clk);
        end

        drive(1'b1, BASE+8, 4'hF, 32'h0, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst wr_gnt", 32'(bus_if.wr_gnt), 32'd0);
        @(negedge clk);
        chk("midrst rd_data", bus_if.rd_data, 32'h0);
        rst_n = 1'b1;
        drive(1'b0, 0, 4'h0, 0, 1'b1, BASE+8);
        #1;
        chk("post rst rd_gnt", 32'(bus_if.rd_gnt), 32'd1);
        @(negedge clk);
        bus_if.rd_req = 1'b0;
        chk("mem kept", bus_if.rd_data, 32'hDEADBEEF);
`else
        do_write("w0", BASE+8, 4'hF, 32'hDEADBEEF);
        do_read("r0", BASE+8, 32'hDEADBEEF);

        drive(1'b1, BASE+8, 4'hF, 32'h0, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("rst wr_gnt c%0d", c), 32'(bus_if.wr_gnt),
                32'd0);
            @(negedge clk);
        end
        chk("rst rd_data", bus_if.rd_data, 32'h0);
        rst_n = 1'b1;
        bus_if.wr_req = 1'b0;
        do_read("r1", BASE+8, 32'hDEADBEEF);

        drive(1'b1, BASE+8, 4'hF, 32'h0, 1'b0, 0);
        repeat (2) @(negedge clk);
        bus_if.wr_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("drop wr_gnt c%0d", c), 32'(bus_if.wr_gnt),
                32'd0);
            @(negedge clk);
        end
        do_read("r2", BASE+8, 32'hDEADBEEF);

        begin
            int lat;
            bit ok;
            drive(1'b1, BASE+12, 4'hF, 32'h55667788, 1'b1, BASE+12);
            wait_gnt(1'b1, lat, ok);
            chk("pri wr first", 32'(ok), 32'd1);
            chk("pri no rd_gnt", 32'(bus_if.rd_gnt), 32'd0);
            @(negedge clk);
            bus_if.wr_req = 1'b0;
            wait_gnt(1'b0, lat, ok);
            chk("pri rd later", 32'(ok), 32'd1);
            chk("pri no wr_gnt", 32'(bus_if.wr_gnt), 32'd0);
            @(negedge clk);
            bus_if.rd_req = 1'b0;
            chk("pri rd_data", bus_if.rd_data, 32'h55667788);
        end

        do_read("miss", BASE+64, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
